uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  UART transmitter; transmit-side counterpart of the UART_RX FSM/sampler path.
//  Accepts one parallel byte per handshake and serialises it on TX_OUT as: start(0), DATA_WIDTH data bits LSB-first, optional parity, stop(1).
//  Runs on the TX bit clock: one clk period = one bit time. No oversampling.
//  Contains the control FSM, serialiser shift register, bit counter, parity generator and output mux.
// PARAMETERS
//  DATA_WIDTH   8   payload bits per frame
//  CNT_WIDTH    4   bit-counter width; must satisfy 2**CNT_WIDTH > DATA_WIDTH
// PORTS
//  clk          in   1           TX bit clock, rising-edge
//  reset_n      in   1           asynchronous, active-low reset
//  P_DATA       in   DATA_WIDTH  parallel byte to send
//  DATA_VALID   in   1           P_DATA valid; single-cycle pulse or level
//  PAR_EN       in   1           1 = append parity bit
//  PAR_TYP      in   1           0 = even parity, 1 = odd parity
//  TX_OUT       out  1           serial line, idle high
//  busy         out  1           high while a frame is on the line
// BEHAVIOUR
//  Reset (async, reset_n=0)
//   - state=IDLE, TX_OUT=1, busy=0, shift reg=0, bit counter=0, parity reg=0.
//   - Asserting reset mid-frame aborts the frame; TX_OUT returns to 1 immediately. No partial resume.
//  FSM states
//   IDLE -> START -> DATA -> PARITY (only if PAR_EN latched=1) -> STOP -> IDLE
//  Acceptance
//   - Acceptance occurs at a rising edge where state=IDLE and DATA_VALID=1.
//   - At that edge, latch P_DATA, PAR_EN and PAR_TYP.
//   - Parity bit = ^P_DATA ^ PAR_TYP.
//   - Input changes after acceptance do not affect the frame.
//   - DATA_VALID is ignored while busy=1; no queueing.
//  Output timing (TX_OUT and busy are registered, both driven from state)
//   - Cycle after acceptance: START, TX_OUT=0, busy=1.
//   - DATA: DATA_WIDTH cycles; TX_OUT = shift[0], shift right each cycle. Bit counter runs 0..DATA_WIDTH-1, then clears.
//   - PARITY: 1 cycle, TX_OUT = latched parity bit.
//   - STOP: 1 cycle, TX_OUT=1, busy=1.
//   - IDLE: TX_OUT=1, busy=0.
//  Frame length and throughput
//   - Frame length: DATA_WIDTH+2 cycles (parity off) or DATA_WIDTH+3 cycles (parity on).
//   - Back-to-back: DATA_VALID held high causes re-acceptance in the first IDLE cycle after STOP. Minimum inter-frame gap is one idle-high bit.
//   - Max throughput: one frame per DATA_WIDTH+3 (parity off) or DATA_WIDTH+4 (parity on) cycles.
//  Other rules
//   - No X on TX_OUT in any state. Unused/illegal state encodings -> IDLE, TX_OUT=1.
//   - busy falls exactly one cycle after the STOP cycle. It is never low while TX_OUT carries frame bits.
// TESTING
//  1. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, 1-cycle DATA_VALID -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; busy high for exactly those 11 cycles.
//  2. P_DATA=0xA5, PAR_EN=1, PAR_TYP=1 -> same frame as test 1, but the parity bit (cycle 10) = 1.
//  3. P_DATA=0x00, PAR_EN=0 -> TX_OUT = 0, eight 0s, 1 over 10 cycles; no parity cycle; busy high for 10 cycles.
//  4. Send 0x3C, then pulse DATA_VALID with P_DATA=0xFF mid-frame and toggle PAR_TYP mid-frame -> 0x3C frame unchanged; 0xFF never sent.
//  5. DATA_VALID held high with 0x81, then 0x7E (switched after first acceptance), PAR_EN=0 -> two frames separated by exactly one idle-high cycle.
//  6. Assert reset_n=0 during data bit 3 of 0x55 -> TX_OUT=1 and busy=0 asynchronously. After release, a new 0x55 request produces a complete, correct frame.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART transmitter running directly on the bit clock (one clk = one bit).
//   Frame on TX_OUT: start(0), DATA_WIDTH data bits LSB-first, optional
//   parity bit, stop(1). The line idles high.
//
// Ports
//   clk        in   TX bit clock, rising edge
//   reset_n    in   asynchronous active-low reset, aborts any frame
//   P_DATA     in   parallel word to send
//   DATA_VALID in   request; taken only when the transmitter is idle
//   PAR_EN     in   1 = append parity bit
//   PAR_TYP    in   0 = even parity, 1 = odd parity
//   TX_OUT     out  serial line (registered)
//   busy       out  high while a frame occupies the line (registered)
//
// Handshake: DATA_VALID has no ready partner. A word is accepted on the
// rising edge where the FSM is IDLE and DATA_VALID=1; busy is then high from
// the next cycle to the end of the stop bit. Requests while busy are dropped.
// -----------------------------------------------------------------------------
module uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic                  r_par_en;
   logic                  r_par;
   logic                  r_tx;
   logic                  r_busy;
   logic                  w_tx_nxt;
   logic                  w_busy_nxt;
   logic                  w_accept;
   logic                  w_last_bit;

   assign w_accept   = (r_state == S_IDLE) && DATA_VALID;
   assign w_last_bit = (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1));

   assign TX_OUT = r_tx;
   assign busy   = r_busy;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state logic; unused encodings fall back to IDLE
   always_comb begin
      w_state_nxt = S_IDLE;
      case (r_state)
         S_IDLE:   w_state_nxt = DATA_VALID ? S_START : S_IDLE;
         S_START:  w_state_nxt = S_DATA;
         S_DATA: begin
            if (w_last_bit) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            else            w_state_nxt = S_DATA;
         end
         S_PARITY: w_state_nxt = S_STOP;
         S_STOP:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Output logic: values the registered outputs take in the next state,
   // so TX_OUT/busy line up with the state without a combinational path.
   always_comb begin
      w_tx_nxt   = 1'b1;
      w_busy_nxt = 1'b1;
      case (w_state_nxt)
         S_IDLE:   w_busy_nxt = 1'b0;
         S_START:  w_tx_nxt   = 1'b0;
         S_DATA:   w_tx_nxt   = r_shift[0];
         S_PARITY: w_tx_nxt   = r_par;
         S_STOP:   w_tx_nxt   = 1'b1;
         default:  w_busy_nxt = 1'b0;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shift  <= '0;
         r_cnt    <= '0;
         r_par_en <= 1'b0;
         r_par    <= 1'b0;
         r_tx     <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         r_tx   <= w_tx_nxt;
         r_busy <= w_busy_nxt;
         if (w_accept) begin
            r_shift  <= P_DATA;
            r_par_en <= PAR_EN;
            r_par    <= (^P_DATA) ^ PAR_TYP;
         end else if (w_state_nxt == S_DATA) begin
            // The bit just loaded into r_tx leaves the register here
            r_shift <= r_shift >> 1;
         end
         if (r_state == S_DATA) begin
            if (w_last_bit) r_cnt <= '0;
            else            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] p_data = 8'h00;
   logic       data_valid = 1'b0;
   logic       par_en = 1'b0;
   logic       par_typ = 1'b0;
   logic       tx_out;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   uart_tx #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .P_DATA    (p_data),
      .DATA_VALID(data_valid),
      .PAR_EN    (par_en),
      .PAR_TYP   (par_typ),
      .TX_OUT    (tx_out),
      .busy      (busy)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- check helper ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // exp_q holds {busy,tx} for every future line cycle of the accepted frame.
   // cur_exp is what the line must show during the present cycle.
   logic [1:0] exp_q[$];
   logic [1:0] cur_exp = 2'b01;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exp_q.delete();
         cur_exp = 2'b01;
      end else begin
         if (cur_exp[1] == 1'b0 && data_valid) begin
            exp_q.push_back(2'b10);
            for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, p_data[i]});
            if (par_en) exp_q.push_back({1'b1, 1'(($countones(p_data) % 2) ^ int'(par_typ))});
            exp_q.push_back(2'b11);
         end
         if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
         else                  cur_exp = 2'b01;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("tx_cycle", 32'(tx_out), 32'(cur_exp[0]));
         chk("busy_cycle", 32'(busy), 32'(cur_exp[1]));
      end
   end

   // ---------------- driver ----------------
   // mode 0: plain request; mode 1: disturb inputs mid-frame;
   // mode 2: hold DATA_VALID high for a second word (0x7E).
   // bits collects TX_OUT samples, first sample ending up most significant.
   task automatic send_cap(input logic [7:0] d, input logic pe, input logic pt,
                           input int ncap, input int mode,
                           output logic [31:0] bits, output int bcnt);
      @(negedge clk);
      p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
      bits = '0;
      bcnt = 0;
      for (int i = 0; i < ncap; i++) begin
         @(negedge clk);
         if (mode != 2 || i == 11) data_valid = 1'b0;
         bits = {bits[30:0], tx_out};
         if (busy) bcnt++;
         if (mode == 1 && i == 4) begin
            data_valid = 1'b1; p_data = 8'hFF; par_typ = ~pt;
         end
         if (mode == 2 && i == 0) p_data = 8'h7E;
         if (mode == 2 && i == 10) chk("gap_busy_low", 32'(busy), 32'd0);
      end
   endtask

   logic [31:0] bits;
   int          bcnt;

   initial begin
      @(negedge clk);
      chk("reset_tx", 32'(tx_out), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk_en = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // 0xA5 even parity
      send_cap(8'hA5, 1'b1, 1'b0, 13, 0, bits, bcnt);
      chk("a5_even_bits", 32'(bits[12:0]), 32'(13'b0101001010111));
      chk("a5_even_busy", 32'(bcnt), 32'd11);

      // 0xA5 odd parity
      send_cap(8'hA5, 1'b1, 1'b1, 13, 0, bits, bcnt);
      chk("a5_odd_bits", 32'(bits[12:0]), 32'(13'b0101001011111));
      chk("a5_odd_busy", 32'(bcnt), 32'd11);

      // 0x00 no parity
      send_cap(8'h00, 1'b0, 1'b0, 12, 0, bits, bcnt);
      chk("zero_nopar_bits", 32'(bits[11:0]), 32'(12'b000000000111));
      chk("zero_nopar_busy", 32'(bcnt), 32'd10);

      // 0x3C with mid-frame input disturbance
      send_cap(8'h3C, 1'b1, 1'b0, 13, 1, bits, bcnt);
      chk("3c_disturb_bits", 32'(bits[12:0]), 32'(13'b0001111000111));
      chk("3c_disturb_busy", 32'(bcnt), 32'd11);
      repeat (3) @(negedge clk);
      chk("no_ff_frame", 32'(busy), 32'd0);

      // back-to-back 0x81 then 0x7E, one idle bit between
      send_cap(8'h81, 1'b0, 1'b0, 23, 2, bits, bcnt);
      chk("b2b_bits", 32'(bits[22:0]), 32'(23'b01000000111001111110111));
      chk("b2b_busy", 32'(bcnt), 32'd20);

      // reset during data bit 3 of 0x55
      @(negedge clk);
      p_data = 8'h55; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_reset_busy", 32'(busy), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_tx", 32'(tx_out), 32'd1);
      chk("async_reset_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      send_cap(8'h55, 1'b1, 1'b0, 13, 0, bits, bcnt);
      chk("55_after_reset_bits", 32'(bits[12:0]), 32'(13'b0101010100111));
      chk("55_after_reset_busy", 32'(bcnt), 32'd11);

      // randomized traffic, checked cycle by cycle against the model
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         data_valid = ($urandom_range(0, 2) == 0);
         p_data     = 8'($urandom);
         par_en     = 1'($urandom_range(0, 1));
         par_typ    = 1'($urandom_range(0, 1));
         if (c == 400) begin
            #3 reset_n = 1'b0;
            #4 reset_n = 1'b1;
         end
      end
      data_valid = 1'b0;
      repeat (15) @(negedge clk);
      chk("final_idle_busy", 32'(busy), 32'd0);
      chk("final_idle_tx", 32'(tx_out), 32'd1);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
